// File: rtl/ultrasonido_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ultrasonido_pkg : shared types and timing constants for the HC-SR04 emulator
// Rev 1.0
// ---------------------------------------------------------------------------
package ultrasonido_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      TRIG_HI = 3'd1,
      BURST   = 3'd2,
      ECHO    = 3'd3,
      HOLDOFF = 3'd4
   } state_t;

   typedef logic [31:0] width_t;

   // Real-sensor timing at 100 MHz
   localparam int unsigned c_trig_min_cyc  = 1000;
   localparam int unsigned c_burst_dly_cyc = 20000;
   localparam int unsigned c_cyc_per_cm    = 5882;
   localparam int unsigned c_min_cm        = 2;
   localparam int unsigned c_max_cm        = 400;
   localparam int unsigned c_timeout_cyc   = 3800000;
   localparam int unsigned c_holdoff_cyc   = 1000000;

   // Shortened timing so simulations finish quickly
   localparam int unsigned c_sim_trig_min_cyc  = 10;
   localparam int unsigned c_sim_burst_dly_cyc = 20;
   localparam int unsigned c_sim_cyc_per_cm    = 5;
   localparam int unsigned c_sim_min_cm        = 2;
   localparam int unsigned c_sim_max_cm        = 400;
   localparam int unsigned c_sim_timeout_cyc   = 3000;
   localparam int unsigned c_sim_holdoff_cyc   = 50;

endpackage
`default_nettype wire

// File: rtl/trig_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trig_sync : 2-flop synchronizer with rise/fall edge detect on the result
// Rev 1.0
// ---------------------------------------------------------------------------
module trig_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_trig,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_trig;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_prev;
   assign o_fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/ultrasonido_emulador.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ultrasonido_emulador : HC-SR04 responder, echo width encodes distance in cm
// Rev 1.0
// ---------------------------------------------------------------------------
module ultrasonido_emulador
   import ultrasonido_pkg::*;
#(
   parameter int unsigned TRIG_MIN_CYC  = c_trig_min_cyc,
   parameter int unsigned BURST_DLY_CYC = c_burst_dly_cyc,
   parameter int unsigned CYC_PER_CM    = c_cyc_per_cm,
   parameter int unsigned MIN_CM        = c_min_cm,
   parameter int unsigned MAX_CM        = c_max_cm,
   parameter int unsigned TIMEOUT_CYC   = c_timeout_cyc,
   parameter int unsigned HOLDOFF_CYC   = c_holdoff_cyc
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trig,
   input  logic [8:0] dist_cm,
   output logic       echo,
   output logic       busy,
   output logic       meas_done,
   output logic       short_trig_err,
   output logic       ign_trig
);

   logic   w_rise;
   logic   w_fall;

   state_t r_state, w_state_nxt;
   width_t r_cnt,   w_cnt_nxt;
   width_t r_width, w_width_nxt;
   logic   r_echo,  w_echo_nxt;
   logic   r_busy;
   logic   r_meas,  w_meas_nxt;
   logic   r_short, w_short_nxt;
   logic   r_ign,   w_ign_nxt;

   width_t w_dist;
   width_t w_d;
   width_t w_echo_width;

   trig_sync u_trig_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_trig (trig),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   assign w_dist       = width_t'(dist_cm);
   assign w_d          = (w_dist < width_t'(MIN_CM)) ? width_t'(MIN_CM) : w_dist;
   assign w_echo_width = (w_d > width_t'(MAX_CM)) ? width_t'(TIMEOUT_CYC)
                                                  : w_d * width_t'(CYC_PER_CM);

   // r_cnt is shared: trig width, burst delay, echo length and holdoff
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_width_nxt = r_width;
      w_echo_nxt  = 1'b0;
      w_meas_nxt  = 1'b0;
      w_short_nxt = 1'b0;
      w_ign_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_state_nxt = TRIG_HI;
               w_cnt_nxt   = '0;
            end
         end
         TRIG_HI: begin
            if (w_fall) begin
               if (r_cnt >= width_t'(TRIG_MIN_CYC)) begin
                  w_width_nxt = w_echo_width;
                  w_state_nxt = BURST;
                  w_cnt_nxt   = width_t'(1);
               end else begin
                  w_short_nxt = 1'b1;
                  w_state_nxt = IDLE;
               end
            end else if (r_cnt < width_t'(TRIG_MIN_CYC)) begin
               w_cnt_nxt = r_cnt + width_t'(1);
            end
         end
         BURST: begin
            // Entry cycle already counts as one cycle after the synchronized fall
            if (r_cnt == width_t'(BURST_DLY_CYC) - width_t'(1)) begin
               w_state_nxt = ECHO;
               w_cnt_nxt   = width_t'(1);
               w_echo_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + width_t'(1);
            end
         end
         ECHO: begin
            if (r_cnt == r_width) begin
               w_state_nxt = HOLDOFF;
               w_cnt_nxt   = width_t'(1);
               w_meas_nxt  = 1'b1;
            end else begin
               w_cnt_nxt  = r_cnt + width_t'(1);
               w_echo_nxt = 1'b1;
            end
         end
         HOLDOFF: begin
            if (r_cnt == width_t'(HOLDOFF_CYC)) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + width_t'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      if (w_rise && (r_state == BURST || r_state == ECHO || r_state == HOLDOFF)) begin
         w_ign_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_width <= '0;
         r_echo  <= 1'b0;
         r_busy  <= 1'b0;
         r_meas  <= 1'b0;
         r_short <= 1'b0;
         r_ign   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_width <= w_width_nxt;
         r_echo  <= w_echo_nxt;
         r_busy  <= (w_state_nxt != IDLE);
         r_meas  <= w_meas_nxt;
         r_short <= w_short_nxt;
         r_ign   <= w_ign_nxt;
      end
   end

   assign echo           = r_echo;
   assign busy           = r_busy;
   assign meas_done      = r_meas;
   assign short_trig_err = r_short;
   assign ign_trig       = r_ign;

endmodule
`default_nettype wire
